// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between an instruction-fetch requester (read-only,
//   32-bit result) and a data requester (load/store, 64-bit). One transaction
//   is in flight at a time: IDLE -> ACCESS -> (WAIT, reads only) -> RESP -> IDLE.
//   Data normally wins arbitration; a starvation counter hands the port to a
//   waiting fetch once STARVE_MAX data grants have been made in a row while
//   the fetch was pending.
//
// Parameters
//   MEM_LAT    memory read latency in cycles (1..7)
//   STARVE_MAX data grants tolerated while fetch waits (1..15)
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   i_req, i_addr              fetch request and byte address
//   i_done, i_rdata            fetch completion pulse, low word of result
//   d_req, d_wr, d_addr,
//   d_wdata                    data request, 1=store, byte address, store data
//   d_done, d_rdata            data completion pulse, load result
//   mem_addr, mem_wr,
//   mem_wdata, mem_rdata       shared memory port
//   busy                       high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_done,
    output logic [63:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } stateType;

    // WAIT lasts MEM_LAT cycles, so the counter starts at MEM_LAT-1 and the
    // cycle in which it reads zero is the one where mem_rdata is valid.
    localparam logic [2:0] WAIT_INIT  = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    stateType    stateReg;
    stateType    stateNext;

    logic        grantFetchReg;   // 1 = current transaction belongs to fetch
    logic        storeReg;        // 1 = current transaction is a data store
    logic [31:0] addrReg;
    logic [63:0] wdataReg;
    logic [2:0]  waitCntReg;
    logic [3:0]  starveCntReg;
    logic [63:0] resultReg;

    logic        anyReq;
    logic        fetchWins;

    assign anyReq = i_req | d_req;

    // Fetch takes the port when it is alone, or when data has already been
    // granted STARVE_MAX times in a row while fetch was waiting.
    assign fetchWins = i_req & (~d_req | (starveCntReg == STARVE_LIM));

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        mem_wr    = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        busy      = 1'b1;
        case (stateReg)
            IDLE: begin
                busy = 1'b0;
                if (anyReq) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                // Decoded from state so that reset pulls it low immediately.
                mem_wr = storeReg;
                if (storeReg) begin
                    stateNext = RESP;
                end else begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (waitCntReg == 3'd0) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                i_done    = grantFetchReg;
                d_done    = ~grantFetchReg;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath ---
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grantFetchReg <= 1'b0;
            storeReg      <= 1'b0;
            addrReg       <= '0;
            wdataReg      <= '0;
            waitCntReg    <= '0;
            starveCntReg  <= '0;
            resultReg     <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (anyReq) begin
                        grantFetchReg <= fetchWins;
                        storeReg      <= ~fetchWins & d_wr;
                        addrReg       <= fetchWins ? i_addr : d_addr;
                        wdataReg      <= d_wdata;
                        if (fetchWins) begin
                            starveCntReg <= '0;
                        end else if (i_req) begin
                            // Data beat a waiting fetch: count it, saturating.
                            if (starveCntReg != STARVE_LIM) begin
                                starveCntReg <= starveCntReg + 4'd1;
                            end
                        end else begin
                            starveCntReg <= '0;
                        end
                    end
                end
                ACCESS: begin
                    waitCntReg <= WAIT_INIT;
                end
                WAIT: begin
                    if (waitCntReg == 3'd0) begin
                        resultReg <= mem_rdata;
                    end else begin
                        waitCntReg <= waitCntReg - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Address and write data hold their last latched values between accesses.
    assign mem_addr  = addrReg;
    assign mem_wdata = wdataReg;
    assign i_rdata   = resultReg[31:0];
    assign d_rdata   = resultReg;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int LAT  = 3;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_wr;
    logic [31:0] i_addr, d_addr;
    logic [63:0] d_wdata;
    logic        i_done, d_done, mem_wr, busy;
    logic [31:0] i_rdata, mem_addr;
    logic [63:0] d_rdata, mem_wdata, mem_rdata;

    // second instance with MEM_LAT=1, data loads only
    logic        l1DReq;
    logic [31:0] l1DAddr;
    logic        l1IDone, l1DDone, l1MemWr, l1Busy;
    logic [31:0] l1IRdata, l1MemAddr;
    logic [63:0] l1DRdata, l1MemWdata, l1MemRdata;

    int vectors;
    int miscompares;
    int starve;
    logic [63:0] refMem [logic [31:0]];

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) dutLat1 (
        .clk(clk), .reset(reset),
        .i_req(1'b0), .i_addr(32'd0), .i_done(l1IDone), .i_rdata(l1IRdata),
        .d_req(l1DReq), .d_wr(1'b0), .d_addr(l1DAddr), .d_wdata(64'd0),
        .d_done(l1DDone), .d_rdata(l1DRdata),
        .mem_addr(l1MemAddr), .mem_wr(l1MemWr), .mem_wdata(l1MemWdata),
        .mem_rdata(l1MemRdata), .busy(l1Busy)
    );

    // Power-on memory contents; two words carry the values used by directed tests.
    function automatic logic [63:0] initWord(input logic [31:0] a);
        if (a == 32'h40)  return 64'h1122334455667788;
        if (a == 32'h100) return 64'hDEADBEEF_CAFEF00D;
        return {a * 32'h9E3779B1, ~a ^ 32'h0F0F1234};
    endfunction

    // ---------------- memory environment (addresses below 0x400) ----------
    logic [63:0] envMem [128];
    bit          envVld [128];
    logic [63:0] pipe   [LAT];
    logic [63:0] l1Pipe;

    function automatic logic [63:0] envRead(input logic [31:0] a);
        return envVld[a[9:3]] ? envMem[a[9:3]] : initWord(a);
    endfunction

    always @(posedge clk) begin
        pipe[0] <= envRead(mem_addr);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        if (mem_wr) begin
            envMem[mem_addr[9:3]] <= mem_wdata;
            envVld[mem_addr[9:3]] <= 1'b1;
        end
        l1Pipe <= initWord(l1MemAddr);
    end
    assign mem_rdata  = pipe[LAT-1];
    assign l1MemRdata = l1Pipe;

    // ---------------- reference model ------------------------------------
    function automatic logic [63:0] refRead(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initWord(a);
    endfunction

    function automatic logic [31:0] randAddr();
        return {22'd0, 7'($urandom_range(0, 127)), 3'b000};
    endfunction

    // Called in an IDLE cycle with requests already driven; runs one whole
    // transaction and returns at the negedge of its completion cycle.
    task automatic grant_cycle(input string tag, output bit expI, output bit gotI);
        bit          expWr;
        int          expLat;
        logic [31:0] expAddr;
        logic [63:0] expData, wd;
        bit          expMw;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_busy: got %b want 0", tag, busy);
        end
        expI = i_req && (!d_req || starve == SMAX);
        if (expI)       starve = 0;
        else if (i_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
        else            starve = 0;
        expWr   = !expI && d_wr;
        expAddr = expI ? i_addr : d_addr;
        expLat  = expWr ? 2 : 2 + LAT;
        expData = refRead(expAddr);
        wd      = d_wdata;
        gotI    = 1'b0;
        for (int c = 1; c <= expLat; c++) begin
            @(negedge clk);
            expMw = (c == 1) && expWr;
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy c%0d: got %b want 1", tag, c, busy);
            end
            vectors++;
            if (mem_wr !== expMw) begin
                miscompares++;
                $display("FAIL %s mem_wr c%0d: got %b want %b", tag, c, mem_wr, expMw);
            end
            if (c == 1) begin
                vectors++;
                if (mem_addr !== expAddr) begin
                    miscompares++;
                    $display("FAIL %s mem_addr: got %h want %h", tag, mem_addr, expAddr);
                end
                if (expWr) begin
                    vectors++;
                    if (mem_wdata !== wd) begin
                        miscompares++;
                        $display("FAIL %s mem_wdata: got %h want %h", tag, mem_wdata, wd);
                    end
                end
            end
            if (c < expLat) begin
                vectors++;
                if ({i_done, d_done} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL %s early_done c%0d: got %b%b want 00", tag, c, i_done, d_done);
                end
            end else begin
                gotI = i_done;
                vectors++;
                if ({i_done, d_done} !== {expI, !expI}) begin
                    miscompares++;
                    $display("FAIL %s done: got i%b d%b want i%b d%b", tag, i_done, d_done, expI, !expI);
                end
                if (expI) begin
                    vectors++;
                    if (i_rdata !== expData[31:0]) begin
                        miscompares++;
                        $display("FAIL %s i_rdata: got %h want %h", tag, i_rdata, expData[31:0]);
                    end
                end else if (!expWr) begin
                    vectors++;
                    if (d_rdata !== expData) begin
                        miscompares++;
                        $display("FAIL %s d_rdata: got %h want %h", tag, d_rdata, expData);
                    end
                end
            end
        end
        if (expWr) refMem[expAddr] = wd;
        $display("txn %s: %s addr=%h lat=%0d starve=%0d", tag,
                 expI ? "fetch" : (expWr ? "store" : "load"), expAddr, expLat, starve);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, mem_wr, i_done, d_done, l1Busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b%b%b%b%b want 00000", busy, mem_wr, i_done, d_done, l1Busy);
        end
        vectors++;
        if ({mem_addr, mem_wdata, d_rdata} !== 160'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h want 0", mem_addr, mem_wdata, d_rdata);
        end
        reset  = 1'b0;
        starve = 0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got %b want 0", busy);
        end
    endtask

    task automatic test_single_load();
        bit e, g;
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h40;
        grant_cycle("load40", e, g);
        vectors++;
        if (d_rdata !== 64'h1122334455667788) begin
            miscompares++;
            $display("FAIL load40_value: got %h want 1122334455667788", d_rdata);
        end
        d_req = 1'b0;
    endtask

    task automatic test_load_lat1();
        @(negedge clk);
        l1DReq = 1'b1; l1DAddr = 32'h40;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (l1MemAddr !== 32'h40) begin
                    miscompares++;
                    $display("FAIL lat1_addr: got %h want 00000040", l1MemAddr);
                end
            end
            if (c < 3) begin
                vectors++;
                if (l1DDone !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lat1_early c%0d: got %b want 0", c, l1DDone);
                end
            end else begin
                vectors++;
                if ({l1DDone, l1IDone, l1MemWr} !== 3'b100) begin
                    miscompares++;
                    $display("FAIL lat1_done: got %b%b%b want 100", l1DDone, l1IDone, l1MemWr);
                end
                vectors++;
                if (l1DRdata !== 64'h1122334455667788) begin
                    miscompares++;
                    $display("FAIL lat1_data: got %h want 1122334455667788", l1DRdata);
                end
                vectors++;
                if ({l1IRdata, l1MemWdata} !== {32'h55667788, 64'd0}) begin
                    miscompares++;
                    $display("FAIL lat1_side: got %h %h want 55667788 0", l1IRdata, l1MemWdata);
                end
            end
        end
        l1DReq = 1'b0;
        $display("txn lat1: load addr=00000040 lat=3");
    endtask

    task automatic test_store();
        bit e, g;
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h80; d_wdata = 64'hAB;
        grant_cycle("store80", e, g);
        vectors++;
        if (g !== 1'b0) begin
            miscompares++;
            $display("FAIL store80_idone: got %b want 0", g);
        end
        d_req = 1'b0; d_wr = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h80;
        grant_cycle("readback80", e, g);
        vectors++;
        if (d_rdata !== 64'hAB) begin
            miscompares++;
            $display("FAIL readback80: got %h want ab", d_rdata);
        end
        d_req = 1'b0;
    endtask

    task automatic test_fetch();
        bit e, g;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h100;
        grant_cycle("fetch100", e, g);
        vectors++;
        if (i_rdata !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL fetch100_value: got %h want cafef00d", i_rdata);
        end
        i_req = 1'b0;
    endtask

    task automatic test_priority_starvation();
        bit e, g;
        bit wantI [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_addr = randAddr();
        grant_cycle("clear", e, g);
        i_req = 1'b1; i_addr = randAddr();
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            grant_cycle($sformatf("starve%0d", n), e, g);
            vectors++;
            if (g !== wantI[n]) begin
                miscompares++;
                $display("FAIL order%0d: got %s want %s", n, g ? "I" : "D", wantI[n] ? "I" : "D");
            end
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        bit e, g;
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h40;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, i_done, d_done, mem_wr} !== 4'b0) begin
            miscompares++;
            $display("FAIL rstwait_ctrl: got %b%b%b%b want 0000", busy, i_done, d_done, mem_wr);
        end
        vectors++;
        if (mem_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL rstwait_addr: got %h want 0", mem_addr);
        end
        d_req = 1'b0;
        starve = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if ({busy, i_done, d_done} !== 3'b0) begin
                miscompares++;
                $display("FAIL rstwait_quiet c%0d: got %b%b%b want 000", c, busy, i_done, d_done);
            end
        end
        d_req = 1'b1; d_addr = 32'h40;
        grant_cycle("after_rst", e, g);
        d_req = 1'b0;
    endtask

    task automatic test_reset_in_store();
        bit e, g;
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h88; d_wdata = {$urandom, $urandom};
        @(negedge clk);
        vectors++;
        if (mem_wr !== 1'b1) begin
            miscompares++;
            $display("FAIL rststore_pre: got %b want 1", mem_wr);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({mem_wr, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL rststore_async: got %b%b want 00", mem_wr, busy);
        end
        d_req = 1'b0; d_wr = 1'b0;
        starve = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h88;
        grant_cycle("dropped88", e, g);
        d_req = 1'b0;
    endtask

    task automatic test_random_single();
        bit e, g;
        int kind;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                i_req = 1'b1; i_addr = randAddr();
            end else begin
                d_req = 1'b1; d_wr = (kind == 2); d_addr = randAddr();
                d_wdata = {$urandom, $urandom};
            end
            grant_cycle($sformatf("rs%0d", n), e, g);
            i_req = 1'b0; d_req = 1'b0;
        end
    endtask

    task automatic test_random_contention();
        bit e, g;
        bit iPend = 1'b0;
        bit dPend = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!iPend && $urandom_range(0, 9) < 7) begin
                iPend = 1'b1; i_addr = randAddr();
            end
            if (!dPend && ($urandom_range(0, 9) < 7 || !iPend)) begin
                dPend = 1'b1; d_wr = $urandom_range(0, 1) == 1;
                d_addr = randAddr(); d_wdata = {$urandom, $urandom};
            end
            i_req = iPend; d_req = dPend;
            grant_cycle($sformatf("rc%0d", n), e, g);
            if (e) iPend = 1'b0;
            else   dPend = 1'b0;
            i_req = iPend; d_req = dPend;
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; starve = 0;
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        l1DReq = 1'b0; l1DAddr = '0;
        test_reset();
        test_single_load();
        test_load_lat1();
        test_store();
        test_fetch();
        test_priority_starvation();
        test_reset_in_wait();
        test_reset_in_store();
        test_random_single();
        test_random_contention();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1: memory read latency in cycles, legal range 1..7.
REQ-002 Parameter STARVE_MAX, default 4: consecutive data grants allowed while fetch is waiting, legal range 1..15.
REQ-003 The block SHALL use one clock, and reset SHALL be asynchronous and active-high. The ports are named clk and reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  async active-high reset.
REQ-006 i_req  in  1  instruction fetch request, read-only.
REQ-007 i_addr  in  32  fetch byte address.
REQ-008 i_done  out  1  one-cycle fetch completion pulse.
REQ-009 i_rdata  out  32  fetch data, low 32 bits of the memory word; valid while i_done=1.
REQ-010 d_req  in  1  data load/store request.
REQ-011 d_wr  in  1  1=store, 0=load.
REQ-012 d_addr  in  32  data byte address.
REQ-013 d_wdata  in  64  store data.
REQ-014 d_done  out  1  one-cycle data completion pulse.
REQ-015 d_rdata  out  64  load data; valid while d_done=1.
REQ-016 mem_addr  out  32  shared memory address.
REQ-017 mem_wr  out  1  shared memory write enable.
REQ-018 mem_wdata  out  64  shared memory write data.
REQ-019 mem_rdata  in  64  shared memory read data, valid MEM_LAT cycles after its address cycle.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, ACCESS, WAIT and RESP. Each transaction SHALL follow the path IDLE->ACCESS->(WAIT for reads only)->RESP->IDLE.
REQ-022 Requests SHALL be sampled only in IDLE. On the edge ending an IDLE cycle with any request high, the block SHALL latch the winner, its address, d_wr and d_wdata, and SHALL move to ACCESS.
REQ-023 In ACCESS, mem_addr and mem_wdata SHALL come from the latched values. mem_wr SHALL be 1 for exactly that cycle, and only for a data store.
REQ-024 A store SHALL go ACCESS->RESP. A load or fetch SHALL go ACCESS->WAIT, stay in WAIT for exactly MEM_LAT cycles (3-bit down-counter), sample mem_rdata on the last WAIT edge into a 64-bit result register, then go to RESP.
REQ-025 In RESP, exactly one of i_done or d_done SHALL be 1, matching the latched winner, and the state SHALL then return to IDLE.
REQ-026 Latency from a request sampled in IDLE cycle N: a store SHALL assert d_done in cycle N+2; a load or fetch SHALL assert its done in cycle N+2+MEM_LAT.
REQ-027 Requesters SHALL hold req and their fields stable until they see done, and SHALL drop req by the following cycle. A req still high in IDLE SHALL be treated as a new request.
REQ-028 Priority: data SHALL win over fetch, except when the starvation counter equals STARVE_MAX and i_req=1, in which case fetch SHALL win.
REQ-029 Starvation counter (4-bit):
- increments, saturating at STARVE_MAX, on each data grant made while i_req=1;
- clears on a fetch grant;
- clears on a data grant made with i_req=0.
REQ-030 If only one request is high, that request SHALL be granted regardless of the counter.
REQ-031 Outside ACCESS, mem_wr SHALL be 0, and mem_addr and mem_wdata SHALL hold their last latched values.
REQ-032 i_rdata and d_rdata SHALL be driven from the result register at all times; their values are meaningful only while the matching done is high.

Reset
REQ-033 Reset SHALL force IDLE immediately (asynchronously) and SHALL clear to 0: mem_wr, i_done, d_done, busy, the starvation counter, the WAIT counter, the result register, mem_addr and mem_wdata.
REQ-034 A reset mid-transaction SHALL drop that transaction with no done pulse. A store in ACCESS SHALL see mem_wr fall asynchronously with reset.

Verification
REQ-035 Single load, MEM_LAT=1: d_req=1, d_wr=0, d_addr=0x40, mem_rdata=0x1122334455667788 -> mem_addr=0x40 in cycle N+1; d_done=1 in cycle N+3 with d_rdata=0x1122334455667788.
REQ-036 Single store: d_wr=1, d_addr=0x80, d_wdata=0xAB -> mem_wr=1 for one cycle (N+1) with mem_addr=0x80 and mem_wdata=0xAB; d_done in N+2; i_done stays 0.
REQ-037 Simultaneous requests: i_req and d_req both high in IDLE -> data granted first. Re-requesting data five times with i_req held high, STARVE_MAX=4 -> grants in the order D,D,D,D,I,D.
REQ-038 Fetch, MEM_LAT=3, i_addr=0x100, mem_rdata=0xDEADBEEF_CAFEF00D -> i_done in cycle N+5 with i_rdata=0xCAFEF00D; busy high in cycles N+1..N+5.
REQ-039 Reset asserted in WAIT -> IDLE immediately; no done pulse; busy=0; the next request completes with the normal latency.
